// File: rtl/dram_req_sched.sv
// dram_req_sched
// In-order DRAM request scheduler between the L2 request path and the DRAM
// command port. It queues L2 requests and tracks the open row of every bank,
// so that each head request is sequenced as a hit (RD/WR), a miss (ACT first)
// or a conflict (PRE, then ACT). It also inserts a periodic all-bank refresh,
// which precharges the open banks and then issues REF.
//
// Ports
//   clk, rst_b        : clock (rising edge), asynchronous active-low reset
//   l2_req_*          : request in (valid/ready); rw=1 write, bank/row/col/data
//   cmd_req/cmd_ack   : four-phase command handshake
//   cmd, cmd_bank/row/col/wdata : command fields, held from issue to retire
//   dram_rdata        : read data, sampled while cmd_ack=1 on a RD
//   rsp_valid/rsp_data: one-cycle read response, returned in request order
//   refresh_busy      : a refresh sequence has started and REF has not retired
module dram_req_sched #(
   parameter int NUM_OF_BANKS     = 8,
   parameter int NUM_OF_ROWS      = 128,
   parameter int NUM_OF_COLS      = 8,
   parameter int DATA_WIDTH       = 8,
   parameter int QUEUE_DEPTH      = 4,
   parameter int REFRESH_INTERVAL = 512,
   localparam int BW = $clog2(NUM_OF_BANKS),
   localparam int RW = $clog2(NUM_OF_ROWS),
   localparam int CW = $clog2(NUM_OF_COLS)
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  l2_req_valid,
   output logic                  l2_req_ready,
   input  logic                  l2_req_rw,
   input  logic [BW-1:0]         l2_req_bank,
   input  logic [RW-1:0]         l2_req_row,
   input  logic [CW-1:0]         l2_req_col,
   input  logic [DATA_WIDTH-1:0] l2_req_data,
   output logic                  cmd_req,
   input  logic                  cmd_ack,
   output logic [2:0]            cmd,
   output logic [BW-1:0]         cmd_bank,
   output logic [RW-1:0]         cmd_row,
   output logic [CW-1:0]         cmd_col,
   output logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [DATA_WIDTH-1:0] dram_rdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  refresh_busy
);

   localparam int QW  = $clog2(QUEUE_DEPTH);
   localparam int QCW = QW + 1;
   localparam int RCW = $clog2(REFRESH_INTERVAL);

   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_ACT = 3'b001;
   localparam logic [2:0] CMD_RD  = 3'b010;
   localparam logic [2:0] CMD_WR  = 3'b011;
   localparam logic [2:0] CMD_PRE = 3'b100;
   localparam logic [2:0] CMD_REF = 3'b101;

   typedef struct packed {
      logic                  rw;
      logic [BW-1:0]         bank;
      logic [RW-1:0]         row;
      logic [CW-1:0]         col;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

   state_t                  state_q, state_d;

   req_t                    q_mem_q [QUEUE_DEPTH];
   req_t                    q_mem_d [QUEUE_DEPTH];
   logic [QW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [QCW-1:0]          count_q, count_d;

   logic [NUM_OF_BANKS-1:0] bank_open_q, bank_open_d;
   logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
   logic [RW-1:0]           open_row_d [NUM_OF_BANKS];

   logic [RCW-1:0]          ref_cnt_q, ref_cnt_d;
   logic                    ref_pend_q, ref_pend_d;
   logic                    ref_busy_q, ref_busy_d;

   logic                    cmd_req_q, cmd_req_d;
   logic [2:0]              cmd_q, cmd_d;
   logic [BW-1:0]           cmd_bank_q, cmd_bank_d;
   logic [RW-1:0]           cmd_row_q, cmd_row_d;
   logic [CW-1:0]           cmd_col_q, cmd_col_d;
   logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic [DATA_WIDTH-1:0]   rd_cap_q, rd_cap_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

   req_t                    head, in_req;
   logic                    push, pop, issue, got_ack, retire, ref_wrap;
   logic                    sel_valid, sel_ref;
   logic [2:0]              sel_cmd;
   logic [BW-1:0]           sel_bank, pre_bank;
   logic [RW-1:0]           sel_row;
   logic [CW-1:0]           sel_col;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   assign l2_req_ready = (count_q < QCW'(QUEUE_DEPTH));
   assign cmd_req      = cmd_req_q;
   assign cmd          = cmd_q;
   assign cmd_bank     = cmd_bank_q;
   assign cmd_row      = cmd_row_q;
   assign cmd_col      = cmd_col_q;
   assign cmd_wdata    = cmd_wdata_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign refresh_busy = ref_busy_q;

   // Command selection. Evaluated every cycle but only acted on in IDLE.
   always_comb begin
      head     = q_mem_q[rd_ptr_q];
      pre_bank = '0;
      // Scan downwards so the lowest-numbered open bank is the one left.
      for (int i = NUM_OF_BANKS - 1; i >= 0; i--) begin
         if (bank_open_q[i]) pre_bank = BW'(i);
      end
      sel_valid = 1'b0;
      sel_ref   = 1'b0;
      sel_cmd   = CMD_NOP;
      sel_bank  = '0;
      sel_row   = '0;
      sel_col   = '0;
      sel_wdata = '0;
      if (ref_pend_q || ref_busy_q) begin
         sel_valid = 1'b1;
         sel_ref   = 1'b1;
         if (|bank_open_q) begin
            sel_cmd  = CMD_PRE;
            sel_bank = pre_bank;
         end else begin
            sel_cmd  = CMD_REF;
         end
      end else if (count_q != '0) begin
         sel_valid = 1'b1;
         sel_bank  = head.bank;
         sel_row   = head.row;
         sel_col   = head.col;
         sel_wdata = head.data;
         if (!bank_open_q[head.bank])                sel_cmd = CMD_ACT;
         else if (open_row_q[head.bank] == head.row) sel_cmd = head.rw ? CMD_WR : CMD_RD;
         else                                        sel_cmd = CMD_PRE;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state. IDLE waits for the previous handshake to be fully
   // released (cmd_ack=0), which also covers a reset taken mid-handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!cmd_ack && sel_valid) state_d = S_REQ;
         S_REQ:   if (cmd_ack)               state_d = S_REL;
         S_REL:   if (!cmd_ack)              state_d = S_IDLE;
         default:                            state_d = S_IDLE;
      endcase
   end

   assign issue   = (state_q == S_IDLE) && (state_d == S_REQ);
   assign got_ack = (state_q == S_REQ)  && cmd_ack;
   assign retire  = (state_q == S_REL)  && !cmd_ack;

   // FSM: outputs (registered command port and read response)
   always_comb begin
      cmd_req_d   = cmd_req_q;
      cmd_d       = cmd_q;
      cmd_bank_d  = cmd_bank_q;
      cmd_row_d   = cmd_row_q;
      cmd_col_d   = cmd_col_q;
      cmd_wdata_d = cmd_wdata_q;
      rd_cap_d    = rd_cap_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      ref_busy_d  = ref_busy_q;
      if (issue) begin
         cmd_req_d   = 1'b1;
         cmd_d       = sel_cmd;
         cmd_bank_d  = sel_bank;
         cmd_row_d   = sel_row;
         cmd_col_d   = sel_col;
         cmd_wdata_d = sel_wdata;
         if (sel_ref) ref_busy_d = 1'b1;
      end
      if (got_ack) begin
         cmd_req_d = 1'b0;
         if (cmd_q == CMD_RD) rd_cap_d = dram_rdata;
      end
      if (retire) begin
         cmd_d = CMD_NOP;
         if (cmd_q == CMD_RD) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_cap_q;
         end
         if (cmd_q == CMD_REF) ref_busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cmd_req_q   <= 1'b0;
         cmd_q       <= CMD_NOP;
         cmd_bank_q  <= '0;
         cmd_row_q   <= '0;
         cmd_col_q   <= '0;
         cmd_wdata_q <= '0;
         rd_cap_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         ref_busy_q  <= 1'b0;
      end else begin
         cmd_req_q   <= cmd_req_d;
         cmd_q       <= cmd_d;
         cmd_bank_q  <= cmd_bank_d;
         cmd_row_q   <= cmd_row_d;
         cmd_col_q   <= cmd_col_d;
         cmd_wdata_q <= cmd_wdata_d;
         rd_cap_q    <= rd_cap_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ref_busy_q  <= ref_busy_d;
      end
   end

   // Queue, bank state and refresh bookkeeping
   always_comb begin
      in_req.rw   = l2_req_rw;
      in_req.bank = l2_req_bank;
      in_req.row  = l2_req_row;
      in_req.col  = l2_req_col;
      in_req.data = l2_req_data;

      push = l2_req_valid && l2_req_ready;
      pop  = retire && ((cmd_q == CMD_RD) || (cmd_q == CMD_WR));

      q_mem_d  = q_mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         q_mem_d[wr_ptr_q] = in_req;
         wr_ptr_d          = wr_ptr_q + QW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + QW'(1);
      count_d = count_q + QCW'(push) - QCW'(pop);

      bank_open_d = bank_open_q;
      open_row_d  = open_row_q;
      if (retire) begin
         case (cmd_q)
            CMD_ACT: begin
               bank_open_d[cmd_bank_q] = 1'b1;
               open_row_d[cmd_bank_q]  = cmd_row_q;
            end
            CMD_PRE: bank_open_d[cmd_bank_q] = 1'b0;
            CMD_REF: bank_open_d = '0;
            default: ;
         endcase
      end

      ref_wrap  = (ref_cnt_q == RCW'(REFRESH_INTERVAL - 1));
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RCW'(1);
      ref_pend_d = ref_pend_q;
      if (retire && (cmd_q == CMD_REF)) ref_pend_d = 1'b0;
      // A wrap landing on the REF retire starts a new refresh round.
      if (ref_wrap) ref_pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q_mem_q     <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         bank_open_q <= '0;
         open_row_q  <= '{default: '0};
         ref_cnt_q   <= '0;
         ref_pend_q  <= 1'b0;
      end else begin
         q_mem_q     <= q_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         bank_open_q <= bank_open_d;
         open_row_q  <= open_row_d;
         ref_cnt_q   <= ref_cnt_d;
         ref_pend_q  <= ref_pend_d;
      end
   end

endmodule

// File: tb/tb_dram_req_sched.sv
// Directed bench for dram_req_sched: reset mid-handshake, closed-bank write,
// row-hit read, row conflict, full queue and refresh sequencing.
module tb_dram_req_sched;
   localparam int BW = 3;
   localparam int RW = 7;
   localparam int CW = 3;
   localparam int DW = 8;

   localparam logic [2:0] C_NOP = 3'd0;
   localparam logic [2:0] C_ACT = 3'd1;
   localparam logic [2:0] C_RD  = 3'd2;
   localparam logic [2:0] C_WR  = 3'd3;
   localparam logic [2:0] C_PRE = 3'd4;
   localparam logic [2:0] C_REF = 3'd5;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          l2_req_valid = 1'b0;
   logic          l2_req_ready;
   logic          l2_req_rw = 1'b0;
   logic [BW-1:0] l2_req_bank = '0;
   logic [RW-1:0] l2_req_row = '0;
   logic [CW-1:0] l2_req_col = '0;
   logic [DW-1:0] l2_req_data = '0;
   logic          cmd_req;
   logic          cmd_ack;
   logic [2:0]    cmd;
   logic [BW-1:0] cmd_bank;
   logic [RW-1:0] cmd_row;
   logic [CW-1:0] cmd_col;
   logic [DW-1:0] cmd_wdata;
   logic [DW-1:0] dram_rdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          refresh_busy;

   logic          ack_force = 1'b0;
   logic          ack_resp = 1'b0;
   logic          resp_en = 1'b0;
   int            ack_dly = 0;
   logic [DW-1:0] rd_val = '0;

   assign cmd_ack = ack_force | ack_resp;

   always #5 clk = ~clk;

   dram_req_sched #(.REFRESH_INTERVAL(64)) dut (
      .clk(clk), .rst_b(rst_b),
      .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
      .l2_req_rw(l2_req_rw), .l2_req_bank(l2_req_bank), .l2_req_row(l2_req_row),
      .l2_req_col(l2_req_col), .l2_req_data(l2_req_data),
      .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd), .cmd_bank(cmd_bank),
      .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wdata(cmd_wdata),
      .dram_rdata(dram_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .refresh_busy(refresh_busy)
   );

   typedef struct packed {
      logic [2:0]    c;
      logic [BW-1:0] b;
      logic [RW-1:0] r;
      logic [CW-1:0] col;
      logic [DW-1:0] d;
      logic          busy;
   } ent_t;

   ent_t          log_q[$];
   logic [DW-1:0] rsp_q[$];
   int            rsp_cyc_q[$];
   int            consec = 0;
   logic          ref_rel_busy = 1'b0;
   logic          mon_prev_req = 1'b0;
   logic          mon_prev_rsp = 1'b0;
   int            cyc = 0;
   int            rst_cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            dly_cnt = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Four-phase responder: ack after ack_dly extra cycles, release once cmd_req drops.
   initial forever begin
      @(negedge clk);
      if (!rst_b) begin
         ack_resp = 1'b0;
         dly_cnt  = 0;
      end else if (resp_en) begin
         if (cmd_req && !ack_resp) begin
            if (dly_cnt >= ack_dly) begin
               ack_resp   = 1'b1;
               dram_rdata = (cmd == C_RD) ? rd_val : '0;
               dly_cnt    = 0;
            end else begin
               dly_cnt++;
            end
         end else if (!cmd_req && ack_resp) begin
            ack_resp = 1'b0;
         end
      end
   end

   // Monitor: log every issued command and every read response.
   initial forever begin
      ent_t e;
      @(negedge clk);
      if (cmd_req && !mon_prev_req) begin
         e.c = cmd; e.b = cmd_bank; e.r = cmd_row; e.col = cmd_col;
         e.d = cmd_wdata; e.busy = refresh_busy;
         log_q.push_back(e);
      end
      if (rsp_valid) begin
         rsp_q.push_back(rsp_data);
         rsp_cyc_q.push_back(cyc);
         if (mon_prev_rsp) consec++;
      end
      if (cmd == C_REF && !cmd_req) ref_rel_busy = refresh_busy;
      mon_prev_req = cmd_req;
      mon_prev_rsp = rsp_valid;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      log_q.delete();
      rsp_q.delete();
      rsp_cyc_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_b = 1'b0;
      ack_force = 1'b0;
      resp_en = 1'b0;
      l2_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      clear_logs();
      rst_b = 1'b1;
      rst_cyc = cyc;
   endtask

   task automatic push(input logic rw, input int b, input int r, input int c,
                       input logic [DW-1:0] d, output int acc);
      int t = 0;
      @(negedge clk);
      l2_req_rw = rw; l2_req_bank = BW'(b); l2_req_row = RW'(r);
      l2_req_col = CW'(c); l2_req_data = d; l2_req_valid = 1'b1;
      while (!l2_req_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      acc = cyc;
      l2_req_valid = 1'b0;
      chk("push accept bound", {31'b0, t < 300}, 32'd1);
   endtask

   task automatic drain(input int n, input string tag);
      int t = 0;
      while (log_q.size() < n && t < 300) begin
         @(negedge clk);
         t++;
      end
      t = 0;
      while ((cmd_req || cmd_ack || cmd != C_NOP) && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk({tag, " cmd count"}, log_q.size(), n);
      chk({tag, " back to NOP"}, {29'b0, cmd}, {29'b0, C_NOP});
   endtask

   int acc;

   initial begin
      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      chk("rst cmd_req", cmd_req, 0);
      chk("rst cmd", cmd, C_NOP);
      chk("rst ready", l2_req_ready, 1);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst refresh_busy", refresh_busy, 0);
      chk("rst rsp_data", rsp_data, 0);
      rst_b = 1'b1;
      rst_cyc = cyc;

      // ---------------- reset mid-handshake ----------------
      push(1'b0, 2, 1, 0, 8'h00, acc);
      @(negedge clk);
      chk("A issue cmd_req", cmd_req, 1);
      chk("A issue cmd", cmd, C_ACT);
      chk("A issue bank", cmd_bank, 2);
      ack_force = 1'b1;
      #2 rst_b = 1'b0;
      #1;
      chk("A async cmd_req", cmd_req, 0);
      chk("A async cmd", cmd, C_NOP);
      chk("A async ready", l2_req_ready, 1);
      @(negedge clk);
      rst_b = 1'b1;
      push(1'b0, 4, 6, 1, 8'h00, acc);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("A held while ack=1 [%0d]", i), cmd_req, 0);
      end
      ack_force = 1'b0;
      @(negedge clk);
      chk("A issue after ack=0", cmd_req, 1);
      chk("A issue after ack=0 cmd", cmd, C_ACT);
      chk("A issue after ack=0 bank", cmd_bank, 4);
      chk("A issue after ack=0 row", cmd_row, 6);

      // ---------------- closed-bank write ----------------
      do_reset();
      resp_en = 1'b1;
      ack_dly = 2;
      push(1'b1, 3, 5, 2, 8'hA5, acc);
      drain(2, "B write");
      chk("B wr[0] cmd", log_q[0].c, C_ACT);
      chk("B wr[0] bank", log_q[0].b, 3);
      chk("B wr[0] row", log_q[0].r, 5);
      chk("B wr[1] cmd", log_q[1].c, C_WR);
      chk("B wr[1] bank", log_q[1].b, 3);
      chk("B wr[1] col", log_q[1].col, 2);
      chk("B wr[1] data", log_q[1].d, 8'hA5);
      chk("B wr no rsp", rsp_q.size(), 0);

      // ---------------- row-hit read ----------------
      clear_logs();
      ack_dly = 0;
      rd_val = 8'h3C;
      push(1'b0, 3, 5, 4, 8'h00, acc);
      drain(1, "B hit");
      chk("B hit cmd", log_q[0].c, C_RD);
      chk("B hit col", log_q[0].col, 4);
      chk("B hit rsp count", rsp_q.size(), 1);
      chk("B hit rsp data", rsp_q[0], 8'h3C);
      chk("B hit latency", rsp_cyc_q[0] - acc, 3);

      // ---------------- row conflict ----------------
      clear_logs();
      rd_val = 8'h5A;
      push(1'b0, 3, 9, 1, 8'h00, acc);
      drain(3, "B conflict");
      chk("B cf[0] cmd", log_q[0].c, C_PRE);
      chk("B cf[0] bank", log_q[0].b, 3);
      chk("B cf[1] cmd", log_q[1].c, C_ACT);
      chk("B cf[1] row", log_q[1].r, 9);
      chk("B cf[2] cmd", log_q[2].c, C_RD);
      chk("B cf[2] col", log_q[2].col, 1);
      chk("B cf rsp count", rsp_q.size(), 1);
      chk("B cf rsp data", rsp_q[0], 8'h5A);
      chk("B cf latency", rsp_cyc_q[0] - acc, 9);

      // ---------------- full queue ----------------
      do_reset();
      resp_en = 1'b1;
      ack_dly = 0;
      push(1'b1, 0, 0, 0, 8'h11, acc);
      drain(2, "C open");
      clear_logs();
      resp_en = 1'b0;
      for (int i = 0; i < 4; i++) push(1'b1, 0, 0, i, DW'(8'h20 + i), acc);
      chk("C ready low after 4th", l2_req_ready, 0);
      @(negedge clk);
      l2_req_col = CW'(4); l2_req_data = 8'h24; l2_req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("C 5th held [%0d]", i), l2_req_ready, 0);
         @(negedge clk);
      end
      resp_en = 1'b1;
      begin
         int t = 0;
         while (!l2_req_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("C ready after retire", l2_req_ready, 1);
      end
      @(negedge clk);
      l2_req_valid = 1'b0;
      drain(5, "C drain");
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("C wr[%0d] cmd", i), log_q[i].c, C_WR);
         chk($sformatf("C wr[%0d] col", i), log_q[i].col, i);
         chk($sformatf("C wr[%0d] data", i), log_q[i].d, 8'h20 + i);
      end

      // ---------------- refresh ----------------
      do_reset();
      resp_en = 1'b1;
      ack_dly = 0;
      push(1'b0, 1, 2, 0, 8'h00, acc);
      push(1'b0, 6, 3, 0, 8'h00, acc);
      drain(4, "D open");
      chk("D open[0] ACT", log_q[0].c, C_ACT);
      chk("D open[2] bank", log_q[2].b, 6);
      clear_logs();
      @(negedge clk);
      ack_force = 1'b1;
      rd_val = 8'h77;
      push(1'b0, 1, 4, 5, 8'h00, acc);
      while (cyc < rst_cyc + 70) @(negedge clk);
      chk("D held before wrap", log_q.size(), 0);
      ack_force = 1'b0;
      drain(5, "D refresh");
      chk("D [0] cmd", log_q[0].c, C_PRE);
      chk("D [0] bank", log_q[0].b, 1);
      chk("D [0] busy", log_q[0].busy, 1);
      chk("D [1] cmd", log_q[1].c, C_PRE);
      chk("D [1] bank", log_q[1].b, 6);
      chk("D [2] cmd", log_q[2].c, C_REF);
      chk("D [2] busy", log_q[2].busy, 1);
      chk("D busy during REF release", ref_rel_busy, 1);
      chk("D [3] cmd", log_q[3].c, C_ACT);
      chk("D [3] bank", log_q[3].b, 1);
      chk("D [3] row", log_q[3].r, 4);
      chk("D [3] busy", log_q[3].busy, 0);
      chk("D [4] cmd", log_q[4].c, C_RD);
      chk("D [4] col", log_q[4].col, 5);
      chk("D rsp count", rsp_q.size(), 1);
      chk("D rsp data", rsp_q[0], 8'h77);
      chk("D busy after", refresh_busy, 0);

      chk("rsp_valid never back-to-back", consec, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dram_req_sched.md
# dram_req_sched

Parametrised request scheduler sitting between the L2 request path and the DRAM command interface. It succeeds the single-request `dram_ctrl` datapath and adds the following:
- an in-order request queue;
- per-bank open-row tracking, with row-hit, row-miss and row-conflict sequencing;
- periodic all-bank refresh.

Every DRAM command goes out over the existing four-phase `cmd_req`/`cmd_ack` handshake.

## Interface
- `NUM_OF_BANKS`, 8, bank count; `BW = $clog2(NUM_OF_BANKS)`
- `NUM_OF_ROWS`, 128, rows per bank; `RW = $clog2(NUM_OF_ROWS)`
- `NUM_OF_COLS`, 8, columns per row; `CW = $clog2(NUM_OF_COLS)`
- `DATA_WIDTH`, 8, data word width
- `QUEUE_DEPTH`, 4, request queue entries (≥2, power of two)
- `REFRESH_INTERVAL`, 512, cycles between refresh requests (≥16)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_b`  in  1  asynchronous, active-low reset
- `l2_req_valid`  in  1  request present
- `l2_req_ready`  out  1  queue can accept
- `l2_req_rw`  in  1  1 = write, 0 = read
- `l2_req_bank`  in  BW  target bank
- `l2_req_row`  in  RW  target row
- `l2_req_col`  in  CW  target column
- `l2_req_data`  in  DATA_WIDTH  write data
- `cmd_req`  out  1  command request (four-phase)
- `cmd_ack`  in  1  command acknowledge
- `cmd`  out  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF
- `cmd_bank`  out  BW  command bank
- `cmd_row`  out  RW  command row (ACT)
- `cmd_col`  out  CW  command column (RD/WR)
- `cmd_wdata`  out  DATA_WIDTH  write data (WR)
- `dram_rdata`  in  DATA_WIDTH  read data, valid while `cmd_ack`=1 on RD
- `rsp_valid`  out  1  one-cycle read-response pulse
- `rsp_data`  out  DATA_WIDTH  read response
- `refresh_busy`  out  1  refresh sequence in progress

## Operation
- **Request queue.**
  - A request is accepted on a clock edge where `l2_req_valid` and `l2_req_ready` are both 1.
  - `l2_req_ready = (count < QUEUE_DEPTH)`. It is derived from the registered count only; a same-cycle pop does not bypass it.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo `QUEUE_DEPTH`.
- **Bank state.** Each bank holds an `open` flag and an `open_row`. All banks are closed after reset.
- **Command selection.** Performed in `IDLE` only, and only when `cmd_ack`=0. Priority:
  1. A refresh sequence is pending or active: PRE the lowest-numbered open bank; if no bank is open, issue REF.
  2. The queue is non-empty. Take the head request (bank b, row r):
     - bank b closed → ACT(b, r);
     - bank b open on row r → RD or WR;
     - bank b open on a different row → PRE(b).
  3. Otherwise stay in `IDLE` with `cmd`=NOP.
- **State machine.**
  - `IDLE` → `REQ` on a selected command. On that edge, `cmd_req` rises and the `cmd*` fields are loaded.
  - `REQ` → `REL` when `cmd_ack`=1 is sampled. On that edge `cmd_req` falls; for an RD, `dram_rdata` is captured at the same edge.
  - `REL` → `IDLE` when `cmd_ack`=0 is sampled. On that edge the command retires.
- **Retire effects.**
  - ACT: sets open/`open_row`.
  - PRE: clears open.
  - REF: clears `refresh_pending`, drops `refresh_busy`, and leaves all banks closed.
  - RD: pops the queue, drives `rsp_valid`=1 for one cycle, and presents the captured data on `rsp_data`.
  - WR: pops the queue.
- **Refresh counter.**
  - Free-running over 0..`REFRESH_INTERVAL`-1.
  - On wrap it sets `refresh_pending`. A wrap while already pending is absorbed; pending is not counted twice.
  - `refresh_busy` rises when `IDLE` first selects a refresh-driven command.
  - A partially sequenced request (e.g. after its ACT) is re-evaluated after the refresh and re-ACTs.
- **Output stability.** The `cmd*` fields are held stable from `REQ` entry until the return to `IDLE`. In `IDLE`, `cmd`=NOP.

## Timing
- **Reset values.** All outputs 0 (`cmd`=NOP), except `l2_req_ready`=1. All banks closed; queue empty; refresh counter 0; state `IDLE`.
- **Reset mid-handshake.** Immediate abort: `cmd_req` goes to 0 asynchronously and there is no retire. After release, `IDLE` waits for `cmd_ack`=0 before issuing anything.
- **Minimum cost.** 3 cycles per command with zero-delay ack: IDLE, REQ, REL.
- **Read latency with zero-delay ack.**
  - Row hit: `rsp_valid` 3 cycles after the head becomes eligible.
  - Closed bank: 6 cycles.
  - Conflict: 9 cycles.
- **Response ordering.** `rsp_valid` never asserts in two consecutive cycles. Responses are returned in request order.
- **Simultaneous events.**
  - Refresh wrap in the same cycle as a retire: the refresh has priority at the next `IDLE` decision.
  - Push while full is ignored, and the request must be held by the source.

## Test plan
- **Reset.** Assert `rst_b`=0 while in `REQ`, with `cmd_ack` held at 1 → `cmd_req`=0 immediately. After release, no command issues until `cmd_ack`=0; `l2_req_ready`=1 and `cmd`=NOP.
- **Closed-bank write.** Write bank 3, row 5, col 2, data 0xA5, ack delay 2 cycles → exactly ACT(3,5) then WR(3,·,2,0xA5); the queue empties.
- **Row-hit read.** Then read bank 3, row 5, col 4, with `dram_rdata`=0x3C during ack → a single RD; `rsp_valid` pulses once with `rsp_data`=0x3C.
- **Row conflict.** Then read bank 3, row 9 → PRE(3), ACT(3,9), RD in order, with one response.
- **Full queue.** `QUEUE_DEPTH`=4, `cmd_ack` held 0, push 5 requests → `l2_req_ready` falls after the 4th accept and the 5th is held. After the first retire, `ready`=1 and the 5th is accepted.
- **Refresh.** `REFRESH_INTERVAL`=64, banks 1 and 6 open, queue non-empty at wrap → PRE(1), PRE(6), REF are issued before any queued command. `refresh_busy` stays high through the REF retire, and the next request then issues ACT.
